// File: rtl/tvip_axi_channel_buffer.sv
// ---------------------------------------------------------------------------------------------
// tvip_axi_channel_buffer
//
// Buffer for a single AXI channel (AW, W, B, AR or R) whose payload is carried as one packed
// vector. Sits between a master-side and a slave-side port to add pipelining or elasticity.
//
// Modes (MODE parameter):
//   0 - pass-through: pure wires, no state, count tied to 0.
//   1 - two-entry register slice (main + skid register), registered s_ready.
//   2 - circular FIFO of DEPTH entries (any DEPTH >= 2), registered s_ready.
//
// Ports:
//   aclk        - clock, all state changes on the rising edge
//   areset      - synchronous, active-high reset
//   s_valid     - upstream valid
//   s_ready     - upstream ready (registered in modes 1/2)
//   s_payload   - upstream payload, WIDTH bits
//   m_valid     - downstream valid
//   m_ready     - downstream ready
//   m_payload   - downstream payload, WIDTH bits, forced to 0 while m_valid is low (modes 1/2)
//   count       - current occupancy
//   almost_full - registered (count >= AFULL_THRESHOLD); only present when the macro
//                 TVIP_AXI_CHANNEL_BUFFER_AFULL_EN is defined
//
// Optional feature macro: TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
// ---------------------------------------------------------------------------------------------
module tvip_axi_channel_buffer #(
    parameter int unsigned  WIDTH           = 64,
    parameter int unsigned  MODE            = 2,
    parameter int unsigned  DEPTH           = 4,
    parameter int unsigned  AFULL_THRESHOLD = DEPTH - 1,
    localparam int unsigned CNT_W           = (MODE == 1) ? 2 : $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_payload,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_payload,
    output logic [CNT_W-1:0] count
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
    ,
    output logic             almost_full
`endif
);

    if (MODE == 0) begin : g_pass
        // ---------------------------------------------------------------------------------
        // Pass-through: zero latency, no storage.
        // ---------------------------------------------------------------------------------
        assign m_valid   = s_valid;
        assign s_ready   = m_ready;
        assign m_payload = s_payload;
        assign count     = '0;
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        assign almost_full = 1'b0;
`endif

    end else if (MODE == 1) begin : g_slice
        // ---------------------------------------------------------------------------------
        // Register slice: main register feeds the output, skid register catches the beat
        // accepted in the cycle the output stalls. s_ready is a flop so m_ready never
        // reaches s_ready combinationally.
        // ---------------------------------------------------------------------------------
        typedef enum logic [1:0] {
            StEmpty = 2'd0,
            StOne   = 2'd1,
            StTwo   = 2'd2
        } slice_state_e;

        slice_state_e     state_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             ready_q;
        logic             valid_q;
        logic [1:0]       cnt_q;
        logic             push;
        logic             pop;

        assign push = s_valid & ready_q;
        assign pop  = valid_q & m_ready;

        always_ff @(posedge aclk) begin
            if (areset) begin
                state_q <= StEmpty;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b0;
                valid_q <= 1'b0;
                cnt_q   <= 2'd0;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        // Also the first cycle out of reset: ready rises here.
                        ready_q <= 1'b1;
                        if (push) begin
                            state_q <= StOne;
                            main_q  <= s_payload;
                            valid_q <= 1'b1;
                            cnt_q   <= 2'd1;
                        end
                    end
                    StOne: begin
                        ready_q <= 1'b1;
                        if (push && !pop) begin
                            state_q <= StTwo;
                            skid_q  <= s_payload;
                            ready_q <= 1'b0;
                            cnt_q   <= 2'd2;
                        end else if (pop && !push) begin
                            state_q <= StEmpty;
                            main_q  <= '0;
                            valid_q <= 1'b0;
                            cnt_q   <= 2'd0;
                        end else if (push && pop) begin
                            main_q <= s_payload;
                        end
                    end
                    StTwo: begin
                        // ready_q is low here, so only a pop can happen.
                        if (pop) begin
                            state_q <= StOne;
                            main_q  <= skid_q;
                            ready_q <= 1'b1;
                            cnt_q   <= 2'd1;
                        end
                    end
                    default: begin
                        state_q <= StEmpty;
                        valid_q <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= 2'd0;
                    end
                endcase
            end
        end

        assign s_ready   = ready_q;
        assign m_valid   = valid_q;
        assign m_payload = valid_q ? main_q : '0;
        assign count     = cnt_q;

`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        logic [1:0] cnt_next;
        logic       afull_q;

        assign cnt_next = cnt_q + 2'(push) - 2'(pop);

        always_ff @(posedge aclk) begin
            if (areset) begin
                afull_q <= 1'b0;
            end else begin
                afull_q <= (32'(cnt_next) >= AFULL_THRESHOLD);
            end
        end

        assign almost_full = afull_q;
`endif

    end else begin : g_fifo
        // ---------------------------------------------------------------------------------
        // Circular FIFO. Pointers wrap explicitly at DEPTH-1 so any depth works.
        // ---------------------------------------------------------------------------------
        localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);
        localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0] wptr_q;
        logic [PTR_W-1:0] rptr_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             ready_q;
        logic             push;
        logic             pop;

        assign push = s_valid & ready_q;
        assign pop  = (cnt_q != '0) & m_ready;

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                cnt_q   <= '0;
                ready_q <= 1'b0;
            end else begin
                if (push) begin
                    wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PTR_W'(1);
                end
                cnt_q   <= cnt_d;
                // Registered from next occupancy: a pop while full reopens ready next cycle.
                ready_q <= (cnt_d < DepthCnt);
            end
        end

        // Storage is not reset; stale entries are unreachable because m_payload is masked.
        always_ff @(posedge aclk) begin
            if (push && !areset) begin
                mem_q[wptr_q] <= s_payload;
            end
        end

        assign s_ready   = ready_q;
        assign m_valid   = (cnt_q != '0);
        assign m_payload = m_valid ? mem_q[rptr_q] : '0;
        assign count     = cnt_q;

`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        logic afull_q;

        always_ff @(posedge aclk) begin
            if (areset) begin
                afull_q <= 1'b0;
            end else begin
                afull_q <= (32'(cnt_d) >= AFULL_THRESHOLD);
            end
        end

        assign almost_full = afull_q;
`endif
    end

endmodule

// File: tb/tb_tvip_axi_channel_buffer.sv
// Bench for tvip_axi_channel_buffer: four instances (pass-through, register slice, FIFO depth 4,
// FIFO depth 3) share one stimulus stream. A queue model per buffered instance predicts the
// outputs each cycle; directed steps add hand-computed literal expectations.
module tb_tvip_axi_channel_buffer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         areset;
    logic         s_valid;
    logic         m_ready;
    logic [W-1:0] s_payload;

    logic         d0_sr, d0_mv, d1_sr, d1_mv, d2_sr, d2_mv, d3_sr, d3_mv;
    logic [W-1:0] d0_mp, d1_mp, d2_mp, d3_mp;
    logic [2:0]   d0_cnt, d2_cnt;
    logic [1:0]   d1_cnt, d3_cnt;
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
    logic         d0_af, d1_af, d2_af, d3_af;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: queue contents and a "first cycle after reset" ready block.
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];
    bit           b1 = 1'b1, b2 = 1'b1, b3 = 1'b1;

    always #5 clk = ~clk;

    tvip_axi_channel_buffer #(.WIDTH(W), .MODE(0)) u_d0 (
        .aclk(clk), .areset(areset), .s_valid(s_valid), .s_ready(d0_sr), .s_payload(s_payload),
        .m_valid(d0_mv), .m_ready(m_ready), .m_payload(d0_mp), .count(d0_cnt)
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        , .almost_full(d0_af)
`endif
    );

    tvip_axi_channel_buffer #(.WIDTH(W), .MODE(1), .AFULL_THRESHOLD(2)) u_d1 (
        .aclk(clk), .areset(areset), .s_valid(s_valid), .s_ready(d1_sr), .s_payload(s_payload),
        .m_valid(d1_mv), .m_ready(m_ready), .m_payload(d1_mp), .count(d1_cnt)
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        , .almost_full(d1_af)
`endif
    );

    tvip_axi_channel_buffer #(.WIDTH(W), .MODE(2), .DEPTH(4), .AFULL_THRESHOLD(3)) u_d2 (
        .aclk(clk), .areset(areset), .s_valid(s_valid), .s_ready(d2_sr), .s_payload(s_payload),
        .m_valid(d2_mv), .m_ready(m_ready), .m_payload(d2_mp), .count(d2_cnt)
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        , .almost_full(d2_af)
`endif
    );

    tvip_axi_channel_buffer #(.WIDTH(W), .MODE(2), .DEPTH(3), .AFULL_THRESHOLD(2)) u_d3 (
        .aclk(clk), .areset(areset), .s_valid(s_valid), .s_ready(d3_sr), .s_payload(s_payload),
        .m_valid(d3_mv), .m_ready(m_ready), .m_payload(d3_mp), .count(d3_cnt)
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        , .almost_full(d3_af)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_buf(input string n, input logic mv, input logic [W-1:0] mp,
                             input logic [31:0] cnt, input logic sr, input int sz,
                             input logic [W-1:0] head, input int cap, input bit blk);
        chk({n, "_m_valid"}, 32'(mv), 32'(sz != 0));
        chk({n, "_m_payload"}, 32'(mp), 32'(head));
        chk({n, "_count"}, cnt, sz);
        chk({n, "_s_ready"}, 32'(sr), 32'(!blk && sz < cap));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare at the falling edge, then advance the model to the next rising edge using the
    // inputs, which only change just after rising edges.
    initial begin : model
        bit p, o;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("d0_m_valid", 32'(d0_mv), 32'(s_valid));
                chk("d0_s_ready", 32'(d0_sr), 32'(m_ready));
                chk("d0_m_payload", 32'(d0_mp), 32'(s_payload));
                chk("d0_count", 32'(d0_cnt), 0);
                check_buf("d1", d1_mv, d1_mp, 32'(d1_cnt), d1_sr, q1.size(),
                          (q1.size() != 0) ? q1[0] : '0, 2, b1);
                check_buf("d2", d2_mv, d2_mp, 32'(d2_cnt), d2_sr, q2.size(),
                          (q2.size() != 0) ? q2[0] : '0, 4, b2);
                check_buf("d3", d3_mv, d3_mp, 32'(d3_cnt), d3_sr, q3.size(),
                          (q3.size() != 0) ? q3[0] : '0, 3, b3);
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
                chk("d0_afull", 32'(d0_af), 0);
                chk("d1_afull", 32'(d1_af), 32'(q1.size() >= 2));
                chk("d2_afull", 32'(d2_af), 32'(q2.size() >= 3));
                chk("d3_afull", 32'(d3_af), 32'(q3.size() >= 2));
`endif
            end
            if (areset) begin
                q1.delete(); q2.delete(); q3.delete();
                b1 = 1'b1; b2 = 1'b1; b3 = 1'b1;
            end else begin
                p = s_valid && !b1 && q1.size() < 2;
                o = m_ready && q1.size() != 0;
                if (o) void'(q1.pop_front());
                if (p) q1.push_back(s_payload);
                p = s_valid && !b2 && q2.size() < 4;
                o = m_ready && q2.size() != 0;
                if (o) void'(q2.pop_front());
                if (p) q2.push_back(s_payload);
                p = s_valid && !b3 && q3.size() < 3;
                o = m_ready && q3.size() != 0;
                if (o) void'(q3.pop_front());
                if (p) q3.push_back(s_payload);
                b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
            end
        end
    end

    logic [W-1:0] fill_v [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    bit           mr_v   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit           rdy_v  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int           cnt_v  [5] = '{0, 1, 2, 2, 1};
    logic [W-1:0] log_q[$];

    initial begin
        areset    = 1'b1;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        s_payload = '0;
        step();
        step();

        // Reset state.
        chk("rst_d2_m_valid", 32'(d2_mv), 0);
        chk("rst_d2_m_payload", 32'(d2_mp), 0);
        chk("rst_d2_count", 32'(d2_cnt), 0);
        chk("rst_d2_s_ready", 32'(d2_sr), 0);
        chk("rst_d1_s_ready", 32'(d1_sr), 0);
        chk_en = 1'b1;
        areset = 1'b0;
        step();
        chk("rel_d2_s_ready", 32'(d2_sr), 1);
        chk("rel_d1_s_ready", 32'(d1_sr), 1);

        // FIFO depth 4: fill with output stalled, then drain in order.
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_payload = fill_v[i];
            step();
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
            if (i == 1) chk("fill_afull_2", 32'(d2_af), 0);
            if (i == 2) chk("fill_afull_3", 32'(d2_af), 1);
`endif
        end
        s_valid = 1'b0;
        chk("full_count", 32'(d2_cnt), 4);
        chk("full_s_ready", 32'(d2_sr), 0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_payload", 32'(d2_mp), 32'(fill_v[i]));
            step();
            if (i == 0) chk("drain_s_ready", 32'(d2_sr), 1);
        end
        chk("drained_m_valid", 32'(d2_mv), 0);
        chk("drained_m_payload", 32'(d2_mp), 0);

        // FIFO depth 3: ten back-to-back beats, one cycle latency, never more than one held.
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_payload = 16'h0100 + W'(i);
            step();
            chk("stream_payload", 32'(d3_mp), 32'h100 + i);
            chk("stream_count", 32'(d3_cnt), 1);
        end
        s_valid = 1'b0;
        step();
        chk("stream_end_count", 32'(d3_cnt), 0);

        // Register slice under m_ready pattern 1,0,0,1,1 with continuous s_valid.
        s_payload = 16'h0200;
        s_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bit acc;
            m_ready = mr_v[c];
            chk("slice_s_ready", 32'(d1_sr), 32'(rdy_v[c]));
            chk("slice_count", 32'(d1_cnt), cnt_v[c]);
            if (d1_mv && m_ready) log_q.push_back(d1_mp);
            acc = d1_sr;
            step();
            if (acc) s_payload = s_payload + 16'h1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (d1_mv && m_ready) log_q.push_back(d1_mp);
            step();
        end
        chk("slice_beats", log_q.size(), 3);
        for (int i = 0; i < log_q.size(); i++) begin
            chk("slice_order", 32'(log_q[i]), 32'h200 + i);
        end

        // Pass-through, same-cycle behaviour.
        m_ready   = 1'b0;
        s_valid   = 1'b1;
        s_payload = 16'hABCD;
        #1;
        chk("pass_m_valid", 32'(d0_mv), 1);
        chk("pass_m_payload", 32'(d0_mp), 32'hABCD);
        chk("pass_s_ready", 32'(d0_sr), 0);
        m_ready = 1'b1;
        #1;
        chk("pass_s_ready_hi", 32'(d0_sr), 1);
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Reset pulsed while three entries are held.
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_payload = 16'h0031 + W'(i);
            step();
        end
        s_valid = 1'b0;
        chk("held_count", 32'(d2_cnt), 3);
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("mid_rst_m_valid", 32'(d2_mv), 0);
        chk("mid_rst_m_payload", 32'(d2_mp), 0);
        chk("mid_rst_count", 32'(d2_cnt), 0);
        chk("mid_rst_s_ready", 32'(d2_sr), 0);
        step();
        chk("mid_rst_s_ready_hi", 32'(d2_sr), 1);

        // Occupancy 3 then one pop.
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_payload = 16'h0041 + W'(i);
            step();
        end
        s_valid = 1'b0;
        chk("af_count3", 32'(d2_cnt), 3);
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        chk("af_high", 32'(d2_af), 1);
`endif
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("af_count2", 32'(d2_cnt), 2);
        chk("af_head", 32'(d2_mp), 32'h42);
`ifdef TVIP_AXI_CHANNEL_BUFFER_AFULL_EN
        chk("af_low", 32'(d2_af), 0);
`endif
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
